systolic_tile_ctrl: RTL

- Tiled-GEMM scheduler for the 4x4 int8 systolic array.
- Computes C[M x N] = (A + input_offset) x B, where M, N and K are multiples of 4 and given as tile counts.
- Fetches 4x4 A/B tiles from two operand buffers and feeds them to the array, accumulating over K.
- Waits for the array to drain, then writes each 4x4 int32 result tile to the output buffer.
- Sits between the accelerator's command/CSR front end and the array plus its operand/result SRAMs.

---
 rtl/systolic_tile_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/systolic_tile_ctrl.sv
// Tiled-GEMM scheduler for a 4x4 int8 systolic array: walks mi/ni/ki tiles,
// feeds A/B tiles to the array, waits for it to drain and writes each int32 C tile.
module systolic_tile_ctrl #(
  parameter int TILE_W = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TILE_W-1:0] m_tiles,
  input  logic [TILE_W-1:0] n_tiles,
  input  logic [TILE_W-1:0] k_tiles,
  input  logic [8:0]        input_offset,
  output logic              busy,
  output logic              done,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_rd_addr,
  input  logic [127:0]      a_rd_data,
  output logic              b_rd_en,
  output logic [ADDR_W-1:0] b_rd_addr,
  input  logic [127:0]      b_rd_data,
  output logic              sa_clear,
  output logic              sa_in_valid,
  output logic [127:0]      sa_row_in,
  output logic [127:0]      sa_col_in,
  output logic [8:0]        sa_input_offset,
  input  logic              sa_busy,
  input  logic [511:0]      sa_data_out,
  output logic              c_wr_en,
  output logic [ADDR_W-1:0] c_wr_addr,
  output logic [511:0]      c_wr_data,
  input  logic              c_wr_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_LOAD,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state;

  logic [TILE_W-1:0] m_reg, n_reg, k_reg;
  logic [TILE_W-1:0] mi_reg, ni_reg, ki_reg;
  // Row/column bases hold mi*k and ni*k, kept incrementally so no multiplier is needed.
  logic [ADDR_W-1:0] a_base_reg, b_base_reg;
  logic              after_load_reg;
  logic              drain_first_reg;

  logic              last_k, last_n, last_m;
  logic [TILE_W-1:0] ki_inc;
  logic [TILE_W-1:0] fetch_ki;

  assign last_k   = (ki_reg == k_reg - TILE_W'(1));
  assign last_n   = (ni_reg == n_reg - TILE_W'(1));
  assign last_m   = (mi_reg == m_reg - TILE_W'(1));
  assign ki_inc   = ki_reg + TILE_W'(1);
  assign fetch_ki = after_load_reg ? ki_inc : ki_reg;

  assign sa_row_in = a_rd_data;
  assign sa_col_in = b_rd_data;
  assign c_wr_data = sa_data_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      m_reg           <= '0;
      n_reg           <= '0;
      k_reg           <= '0;
      mi_reg          <= '0;
      ni_reg          <= '0;
      ki_reg          <= '0;
      a_base_reg      <= '0;
      b_base_reg      <= '0;
      after_load_reg  <= 1'b0;
      drain_first_reg <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      a_rd_en         <= 1'b0;
      a_rd_addr       <= '0;
      b_rd_en         <= 1'b0;
      b_rd_addr       <= '0;
      sa_clear        <= 1'b0;
      sa_in_valid     <= 1'b0;
      sa_input_offset <= '0;
      c_wr_en         <= 1'b0;
      c_wr_addr       <= '0;
    end else begin
      done        <= 1'b0;
      a_rd_en     <= 1'b0;
      b_rd_en     <= 1'b0;
      sa_clear    <= 1'b0;
      sa_in_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            m_reg           <= m_tiles;
            n_reg           <= n_tiles;
            k_reg           <= k_tiles;
            sa_input_offset <= input_offset;
            busy            <= 1'b1;
            if (m_tiles == '0 || n_tiles == '0 || k_tiles == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              mi_reg     <= '0;
              ni_reg     <= '0;
              ki_reg     <= '0;
              a_base_reg <= '0;
              b_base_reg <= '0;
              c_wr_addr  <= '0;
              sa_clear   <= 1'b1;
              state      <= S_CLEAR;
            end
          end
        end

        S_CLEAR: begin
          after_load_reg  <= 1'b0;
          drain_first_reg <= 1'b1;
          state           <= S_DRAIN;
        end

        S_FETCH: begin
          sa_in_valid <= 1'b1;
          state       <= S_LOAD;
        end

        S_LOAD: begin
          after_load_reg  <= 1'b1;
          drain_first_reg <= 1'b1;
          state           <= S_DRAIN;
        end

        S_DRAIN: begin
          // sa_busy is registered in the array, so the first drain cycle cannot see it yet.
          if (drain_first_reg) begin
            drain_first_reg <= 1'b0;
          end else if (!sa_busy) begin
            if (after_load_reg && last_k) begin
              c_wr_en <= 1'b1;
              state   <= S_WRITE;
            end else begin
              ki_reg    <= fetch_ki;
              a_rd_addr <= a_base_reg + ADDR_W'(fetch_ki);
              b_rd_addr <= b_base_reg + ADDR_W'(fetch_ki);
              a_rd_en   <= 1'b1;
              b_rd_en   <= 1'b1;
              state     <= S_FETCH;
            end
          end
        end

        S_WRITE: begin
          if (c_wr_ready) begin
            c_wr_en   <= 1'b0;
            ki_reg    <= '0;
            // mi-major, ni-minor order makes the C tile address a plain running count.
            c_wr_addr <= c_wr_addr + ADDR_W'(1);
            if (last_n) begin
              ni_reg     <= '0;
              b_base_reg <= '0;
              if (last_m) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                mi_reg     <= mi_reg + TILE_W'(1);
                a_base_reg <= a_base_reg + ADDR_W'(k_reg);
                sa_clear   <= 1'b1;
                state      <= S_CLEAR;
              end
            end else begin
              ni_reg     <= ni_reg + TILE_W'(1);
              b_base_reg <= b_base_reg + ADDR_W'(k_reg);
              sa_clear   <= 1'b1;
              state      <= S_CLEAR;
            end
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
